// File: rtl/mult_scaler.sv
`default_nettype none
// ============================================================================
// Module   : mult_scaler
// Brief    : Sequential shift-and-add signed x unsigned scaled multiplier
//            with once/done handshake and 4-bit shift-select/bypass code.
// Revision : 1.0 - initial release
// ============================================================================
module mult_scaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         once,
    output logic         done,
    output logic         busy,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [3:0]   shift,
    output logic [W-1:0] out,
    output logic         sat
);

    localparam int                   c_CNT_W  = $clog2(W + 1);
    localparam logic [c_CNT_W-1:0]   c_ONE_C  = 1;
    localparam logic [c_CNT_W-1:0]   c_LAST   = c_CNT_W'(W);
    localparam logic [W-1:0]         c_ONE_W  = 1;
    localparam logic [2*W-1:0]       c_MAX_M  = (2*W)'((1 << (W - 1)) - 1);
    localparam logic [W-1:0]         c_MAX_W  = c_MAX_M[W-1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*W-1:0]       r_acc;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_sign;
    logic [3:0]           r_shift;

    logic                 w_bypass;
    logic [W-1:0]         w_mag_in;
    logic [2*W-1:0]       w_addend;
    logic [7:0]           w_rsh;
    logic [2*W-1:0]       w_m;
    logic                 w_sat;
    logic [W-1:0]         w_mag;
    logic [W-1:0]         w_result;

    assign w_bypass = (shift == 4'h0) || (shift == 4'hF);
    // Magnitude of the most negative operand is representable as unsigned
    assign w_mag_in = in0[W-1] ? (~in0 + c_ONE_W) : in0;
    assign w_addend = {{W{1'b0}}, r_a} << (r_cnt - c_ONE_C);

    assign w_rsh    = 8'(W) - {4'd0, r_shift};
    assign w_m      = r_acc >> w_rsh;
    assign w_sat    = (w_m > c_MAX_M);
    assign w_mag    = w_sat ? c_MAX_W : w_m[W-1:0];
    // Clamped magnitude keeps negative results at or above -(2^(W-1)-1)
    assign w_result = r_sign ? (~w_mag + c_ONE_W) : w_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (once && !w_bypass) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            busy    <= 1'b0;
            out     <= '0;
            sat     <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sign  <= 1'b0;
            r_shift <= 4'h0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (once) begin
                        if (shift == 4'h0) begin
                            out  <= in0;
                            sat  <= 1'b0;
                            done <= 1'b1;
                        end else if (shift == 4'hF) begin
                            out  <= in1;
                            sat  <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            r_sign  <= in0[W-1];
                            r_a     <= w_mag_in;
                            r_b     <= in1;
                            r_acc   <= '0;
                            r_shift <= shift;
                            r_cnt   <= c_ONE_C;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_b[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + c_ONE_C;
                end
                S_FINISH: begin
                    out   <= w_result;
                    sat   <= w_sat;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    r_cnt <= '0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
